// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath defaults, ALU operation codes and
// forwarding-select codes used by the execute stage and its ALU.
package pipeline_pkg;

  // Datapath defaults
  localparam int WIDTH_DEF = 32;
  localparam int REGW_DEF  = 5;

  // ALU operation codes produced by the ID-stage ALU decoder
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLLV = 3'b011;
  localparam logic [2:0] ALU_SRAV = 3'b100;
  localparam logic [2:0] ALU_ZERO = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  // Operand forwarding selects (2'b11 is treated like FWD_REG)
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational EX-stage ALU. Results wrap modulo 2^WIDTH; overflow is
// deliberately not reported. Variable shifts use only the low five bits of A.
module alu
  import pipeline_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  input  logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Select the ALU result for the current operation and derive the zero flag
  always_comb begin
    result = {WIDTH{1'b0}};
    case (alu_sel)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_SLL:  result = b << shamt;
      ALU_SLLV: result = b << a[4:0];
      ALU_SRAV: result = $signed(b) >>> a[4:0];
      ALU_ZERO: result = {WIDTH{1'b0}};
      default:  result = {WIDTH{1'b0}};
    endcase
    zero = (result == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage pipeline: ID/EX register, operand forwarding,
// ALU, and the EX/MEM register that feeds the MEM stage. A bubble in either
// register is an all-zero entry, so its control bits can never write state.
module execute_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REGW  = REGW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             ValidD,
  input  logic [2:0]       ALUSelD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             MemtoRegD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] SignImmD,
  input  logic [REGW-1:0]  RsD,
  input  logic [REGW-1:0]  RtD,
  input  logic [REGW-1:0]  RdD,
  input  logic [4:0]       ShamtD,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  output logic [REGW-1:0]  RsE,
  output logic [REGW-1:0]  RtE,
  output logic             ValidM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [REGW-1:0]  WriteRegM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic             ZeroM
);

  // ID/EX pipeline register contents (RsE/RtE are driven directly)
  logic             valid_e;
  logic [2:0]       alu_sel_e;
  logic             alu_src_e;
  logic             reg_dst_e;
  logic             reg_write_e;
  logic             mem_write_e;
  logic             memto_reg_e;
  logic [WIDTH-1:0] rd1_e;
  logic [WIDTH-1:0] rd2_e;
  logic [WIDTH-1:0] imm_e;
  logic [REGW-1:0]  rd_e;
  logic [4:0]       shamt_e;

  // EX-stage combinational values
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic [REGW-1:0]  write_reg_e;

  // ID/EX register: flush inserts a bubble, stall holds, otherwise capture ID
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e     <= 1'b0;
      alu_sel_e   <= 3'b000;
      alu_src_e   <= 1'b0;
      reg_dst_e   <= 1'b0;
      reg_write_e <= 1'b0;
      mem_write_e <= 1'b0;
      memto_reg_e <= 1'b0;
      rd1_e       <= {WIDTH{1'b0}};
      rd2_e       <= {WIDTH{1'b0}};
      imm_e       <= {WIDTH{1'b0}};
      RsE         <= {REGW{1'b0}};
      RtE         <= {REGW{1'b0}};
      rd_e        <= {REGW{1'b0}};
      shamt_e     <= 5'd0;
    end else if (Flush) begin
      valid_e     <= 1'b0;
      alu_sel_e   <= 3'b000;
      alu_src_e   <= 1'b0;
      reg_dst_e   <= 1'b0;
      reg_write_e <= 1'b0;
      mem_write_e <= 1'b0;
      memto_reg_e <= 1'b0;
      rd1_e       <= {WIDTH{1'b0}};
      rd2_e       <= {WIDTH{1'b0}};
      imm_e       <= {WIDTH{1'b0}};
      RsE         <= {REGW{1'b0}};
      RtE         <= {REGW{1'b0}};
      rd_e        <= {REGW{1'b0}};
      shamt_e     <= 5'd0;
    end else if (!Stall) begin
      valid_e     <= ValidD;
      alu_sel_e   <= ALUSelD;
      alu_src_e   <= ALUSrcD;
      reg_dst_e   <= RegDstD;
      reg_write_e <= RegWriteD;
      mem_write_e <= MemWriteD;
      memto_reg_e <= MemtoRegD;
      rd1_e       <= RD1D;
      rd2_e       <= RD2D;
      imm_e       <= SignImmD;
      RsE         <= RsD;
      RtE         <= RtD;
      rd_e        <= RdD;
      shamt_e     <= ShamtD;
    end
  end

  // Forwarding muxes; the MEM source is the current EX/MEM register
  always_comb begin
    fwd_a = rd1_e;
    fwd_b = rd2_e;
    case (ForwardAE)
      FWD_REG: fwd_a = rd1_e;
      FWD_WB:  fwd_a = ResultW;
      FWD_MEM: fwd_a = ALUOutM;
      default: fwd_a = rd1_e;
    endcase
    case (ForwardBE)
      FWD_REG: fwd_b = rd2_e;
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALUOutM;
      default: fwd_b = rd2_e;
    endcase
  end

  // Operand B immediate select and destination register select
  always_comb begin
    op_b        = fwd_b;
    write_reg_e = RtE;
    if (alu_src_e) begin
      op_b = imm_e;
    end else begin
      op_b = fwd_b;
    end
    if (reg_dst_e) begin
      write_reg_e = rd_e;
    end else begin
      write_reg_e = RtE;
    end
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a       (fwd_a),
    .b       (op_b),
    .shamt   (shamt_e),
    .alu_sel (alu_sel_e),
    .result  (alu_result),
    .zero    (alu_zero)
  );

  // EX/MEM register: bubble on stall or an invalid EX entry, else capture EX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidM     <= 1'b0;
      ALUOutM    <= {WIDTH{1'b0}};
      WriteDataM <= {WIDTH{1'b0}};
      WriteRegM  <= {REGW{1'b0}};
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      ZeroM      <= 1'b0;
    end else if (Stall || !valid_e) begin
      ValidM     <= 1'b0;
      ALUOutM    <= {WIDTH{1'b0}};
      WriteDataM <= {WIDTH{1'b0}};
      WriteRegM  <= {REGW{1'b0}};
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      ZeroM      <= 1'b0;
    end else begin
      ValidM     <= 1'b1;
      ALUOutM    <= alu_result;
      WriteDataM <= fwd_b;
      WriteRegM  <= write_reg_e;
      RegWriteM  <= reg_write_e;
      MemWriteM  <= mem_write_e;
      MemtoRegM  <= memto_reg_e;
      ZeroM      <= alu_zero;
    end
  end

endmodule
